csr_exec_unit: RTL and testbench
================================

Name: csr_exec_unit

Overview:
- Execute-side sequencer that sits directly upstream of the machine-mode CSR file.
- Accepts one decoded SYSTEM-class instruction at a time over a valid/ready handshake: csrrw/s/c, csrrw/s/ci, ecall, mret.
- Performs read-modify-write against the CSR file and drives its write, ecall and mret strobes.
- Returns the rd writeback value and any PC redirect (trap entry to mtvec, return to mepc) downstream over a second valid/ready handshake.

Parameters:
XLEN, 32, register and CSR data width
MCAUSE_ECALL, 11, mcause value written on ecall from M-mode

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
in_valid_i  in  1  upstream instruction valid
in_ready_o  out  1  unit can accept an instruction
pc_i  in  XLEN  PC of the instruction
src1_i  in  XLEN  rs1 register value
rs1_idx_i  in  5  rs1 field; doubles as zimm for immediate forms
rd_i  in  5  destination register index
csr_addr_i  in  12  CSR address field
csr_op_i  in  3  funct3
is_ecall_i  in  1  instruction is ecall
is_mret_i  in  1  instruction is mret
csr_addr_o  out  12  CSR address to the CSR file
csr_rdata_i  in  XLEN  CSR file read data (mtvec while ecall strobe high, mepc while mret strobe high)
csr_wdata_o  out  XLEN  CSR write data
csr_wen_o  out  1  CSR write enable
csr_ecall_o  out  1  ecall strobe to the CSR file
csr_mret_o  out  1  mret strobe to the CSR file
csr_mepc_o  out  XLEN  mepc value for ecall
csr_mcause_o  out  XLEN  mcause value for ecall
out_valid_i? no: out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
rd_o  out  5  writeback index
rd_wdata_o  out  XLEN  old CSR value
rd_wen_o  out  1  register write enable
redirect_o  out  1  PC redirect required
redirect_pc_o  out  XLEN  redirect target

Behaviour:
- FSM states: IDLE, READ, WRITE, DONE. One instruction in flight; latency is 3 cycles from input handshake to out_valid_o.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&in_ready_o, latch all inputs and go to READ.
- READ:
  - csr_addr_o = latched address.
  - Capture csr_rdata_i into old_q.
  - csr_ecall_o / csr_mret_o asserted when the latched op is ecall / mret, so the CSR file muxes mtvec / mepc.
  - Go to WRITE.
- WRITE (csr_wen_o is high for exactly this one cycle):
  - RW: wdata = src1.
  - RS: wdata = old|src1.
  - RC: wdata = old&~src1.
  - RWI/RSI/RCI: same, using the zero-extended 5-bit rs1_idx.
  - csr_wen_o=1, except RS/RC/RSI/RCI with rs1_idx==0, where there is no write.
  - ecall: csr_ecall_o=1, csr_wen_o=1, csr_mepc_o=pc, csr_mcause_o=MCAUSE_ECALL.
  - mret: csr_mret_o=1, csr_wen_o=1.
  - Go to DONE.
- DONE:
  - out_valid_o=1 until out_ready_i.
  - rd_wdata_o=old_q.
  - rd_wen_o=1 only for CSR ops with rd!=0.
  - redirect_o=1 with redirect_pc_o=old_q for ecall and mret.
  - Outputs hold stable while stalled.
  - On handshake, go to IDLE.
- csr_mepc_o and csr_mcause_o are held valid in both READ and WRITE. The CSR file writes mepc/mcause on the ecall strobe alone; a double write of the same value is harmless.
- Priority: is_ecall_i > is_mret_i > csr_op_i.
- csr_op_i 000 without ecall/mret, and 100, are no-ops: no CSR write, rd_wen_o=0, redirect_o=0.
- Reset, asynchronous at any state:
  - FSM to IDLE; all outputs 0 except in_ready_o, which is 1 after reset.
  - The in-flight instruction is discarded; csr_wen_o never glitches high during reset.

Optional Feature:
- Macro CSR_EXEC_ILLEGAL_TRAP_EN.
- Defined: funct3 100, or a CSR address outside {mstatus, mtvec, mepc, mcause}, is treated as a trap:
  - ecall strobes driven as for ecall;
  - mcause=2, mepc=pc;
  - no CSR data write; rd_wen_o=0;
  - redirect_o=1 to mtvec.
- Undefined: these cases are no-ops as described in Behaviour.

Decomposition:
- Shared package holds:
  - CSR address constants: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342;
  - funct3 encodings RW=001, RS=010, RC=011, RWI=101, RSI=110, RCI=111;
  - FSM state typedef;
  - mcause codes (ecall 11, illegal 2).
- One natural sub-module: csr_wdata_alu, the combinational RW/RS/RC/immediate write-data computation.

Test Plan:
- csrrw mtvec(0x305), src1=0x80000100, rd=5, old=0:
  - csr_wen_o high one cycle with wdata 0x80000100;
  - out_valid_o 3 cycles after accept, rd_wdata_o=0, rd_wen_o=1.
- csrrs mstatus, old=0x1800, src1=0x8:
  - wdata 0x1808, rd_wdata_o=0x1800.
- csrrc with rs1_idx=0:
  - csr_wen_o stays 0; rd still receives the old value.
- ecall at pc=0x80000040, mtvec=0x80000100:
  - csr_ecall_o high in READ and WRITE, mepc=0x80000040, mcause=11;
  - redirect_o=1, redirect_pc_o=0x80000100, rd_wen_o=0.
- mret with mepc=0x80000044:
  - redirect_pc_o=0x80000044.
  - out_ready_i held low 4 cycles: outputs stable throughout, in_ready_o=0.
- Assert rst_i low during WRITE:
  - FSM immediately to IDLE, csr_wen_o=0, in_ready_o=1 after release;
  - a subsequent csrrwi (zimm=7) completes normally.

Source files
------------

// File: rtl/csr_exec_unit_pkg.sv
// Shared constants and types for the CSR execute sequencer: CSR addresses,
// funct3 encodings, FSM/instruction-kind enums and mcause codes.
package csr_exec_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [2:0] F3_RW   = 3'b001;
  localparam logic [2:0] F3_RS   = 3'b010;
  localparam logic [2:0] F3_RC   = 3'b011;
  localparam logic [2:0] F3_ILL  = 3'b100;
  localparam logic [2:0] F3_RWI  = 3'b101;
  localparam logic [2:0] F3_RSI  = 3'b110;
  localparam logic [2:0] F3_RCI  = 3'b111;

  localparam int MCAUSE_ECALL_CODE   = 11;
  localparam int MCAUSE_ILLEGAL_CODE = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    K_NOP   = 3'd0,
    K_CSR   = 3'd1,
    K_ECALL = 3'd2,
    K_MRET  = 3'd3,
    K_ILL   = 3'd4
  } kind_t;

  function automatic logic csr_addr_legal(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/csr_exec_unit_alu.sv
// Combinational CSR write-data: RW/RS/RC on rs1 value or zero-extended zimm.
module csr_exec_unit_alu #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src1,
  input  logic [4:0]      zimm,
  output logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] operand;

  // funct3[2] selects the immediate forms; funct3[1:0] selects RW/RS/RC
  assign operand = op[2] ? {{(XLEN-5){1'b0}}, zimm} : src1;

  always_comb begin
    wdata = old_val;
    unique case (op[1:0])
      2'b01:   wdata = operand;
      2'b10:   wdata = old_val | operand;
      2'b11:   wdata = old_val & ~operand;
      default: wdata = old_val;
    endcase
  end

endmodule

// File: rtl/csr_exec_unit.sv
// SYSTEM-instruction sequencer (IDLE/READ/WRITE/DONE), out_valid_o 3 cycles after accept, one in flight;
// result holds while out_ready_i is low. CSR_EXEC_ILLEGAL_TRAP_EN turns bad funct3/address into a trap.
module csr_exec_unit #(
  parameter int XLEN         = 32,
  parameter int MCAUSE_ECALL = 11
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic [4:0]      rd_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [2:0]      csr_op_i,
  input  logic            is_ecall_i,
  input  logic            is_mret_i,
  output logic [11:0]     csr_addr_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            csr_wen_o,
  output logic            csr_ecall_o,
  output logic            csr_mret_o,
  output logic [XLEN-1:0] csr_mepc_o,
  output logic [XLEN-1:0] csr_mcause_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] rd_wdata_o,
  output logic            rd_wen_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);
  import csr_exec_unit_pkg::*;

  state_t          state_q;
  kind_t           kind_d, kind_q;
  logic [XLEN-1:0] src1_q, old_q, alu_wdata, mcause_d;
  logic [4:0]      rs1_q, rd_q;
  logic [2:0]      op_q;
  logic            wen_d, is_trap_d;

  // ecall beats mret beats the funct3 field
  always_comb begin
    kind_d = K_NOP;
    if (is_ecall_i)                kind_d = K_ECALL;
    else if (is_mret_i)            kind_d = K_MRET;
    else if (csr_op_i[1:0] != 2'b00) kind_d = K_CSR;
`ifdef CSR_EXEC_ILLEGAL_TRAP_EN
    if (!is_ecall_i && !is_mret_i &&
        ((csr_op_i == F3_ILL) || ((kind_d == K_CSR) && !csr_addr_legal(csr_addr_i))))
      kind_d = K_ILL;
`endif
  end

  assign is_trap_d = (kind_d == K_ECALL) || (kind_d == K_ILL);
  assign mcause_d  = (kind_d == K_ILL) ? XLEN'(MCAUSE_ILLEGAL_CODE) : XLEN'(MCAUSE_ECALL);

  // Set/clear forms with rs1/zimm == 0 must not write (read-only CSRs stay untouched)
  always_comb begin
    wen_d = 1'b0;
    unique case (kind_q)
      K_CSR:          wen_d = !(op_q[1] && (rs1_q == 5'd0));
      K_ECALL, K_MRET: wen_d = 1'b1;
      default:        wen_d = 1'b0;
    endcase
  end

  csr_exec_unit_alu #(.XLEN(XLEN)) u_alu (
    .op      (op_q),
    .old_val (csr_rdata_i),
    .src1    (src1_q),
    .zimm    (rs1_q),
    .wdata   (alu_wdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      kind_q        <= K_NOP;
      src1_q        <= '0;
      rs1_q         <= '0;
      rd_q          <= '0;
      op_q          <= '0;
      old_q         <= '0;
      in_ready_o    <= 1'b1;
      csr_addr_o    <= '0;
      csr_wdata_o   <= '0;
      csr_wen_o     <= 1'b0;
      csr_ecall_o   <= 1'b0;
      csr_mret_o    <= 1'b0;
      csr_mepc_o    <= '0;
      csr_mcause_o  <= '0;
      out_valid_o   <= 1'b0;
      rd_o          <= '0;
      rd_wdata_o    <= '0;
      rd_wen_o      <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            state_q      <= S_READ;
            in_ready_o   <= 1'b0;
            kind_q       <= kind_d;
            src1_q       <= src1_i;
            rs1_q        <= rs1_idx_i;
            rd_q         <= rd_i;
            op_q         <= csr_op_i;
            csr_addr_o   <= csr_addr_i;
            csr_ecall_o  <= is_trap_d;
            csr_mret_o   <= (kind_d == K_MRET);
            csr_mepc_o   <= is_trap_d ? pc_i : '0;
            csr_mcause_o <= is_trap_d ? mcause_d : '0;
          end
        end
        S_READ: begin
          state_q     <= S_WRITE;
          old_q       <= csr_rdata_i;
          csr_wdata_o <= (kind_q == K_CSR) ? alu_wdata : '0;
          csr_wen_o   <= wen_d;
        end
        S_WRITE: begin
          state_q       <= S_DONE;
          csr_addr_o    <= '0;
          csr_wdata_o   <= '0;
          csr_wen_o     <= 1'b0;
          csr_ecall_o   <= 1'b0;
          csr_mret_o    <= 1'b0;
          csr_mepc_o    <= '0;
          csr_mcause_o  <= '0;
          out_valid_o   <= 1'b1;
          rd_o          <= rd_q;
          rd_wdata_o    <= old_q;
          rd_wen_o      <= (kind_q == K_CSR) && (rd_q != 5'd0);
          redirect_o    <= (kind_q == K_ECALL) || (kind_q == K_MRET) || (kind_q == K_ILL);
          redirect_pc_o <= ((kind_q == K_ECALL) || (kind_q == K_MRET) || (kind_q == K_ILL)) ?
                           old_q : '0;
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_q       <= S_IDLE;
            in_ready_o    <= 1'b1;
            out_valid_o   <= 1'b0;
            rd_o          <= '0;
            rd_wdata_o    <= '0;
            rd_wen_o      <= 1'b0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit: hand-computed vectors, CSR read data driven per instruction.
module tb_csr_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] pc_i = '0;
  logic [31:0] src1_i = '0;
  logic [4:0]  rs1_idx_i = '0;
  logic [4:0]  rd_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic [2:0]  csr_op_i = '0;
  logic        is_ecall_i = 1'b0;
  logic        is_mret_i = 1'b0;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_rdata_i = '0;
  logic [31:0] csr_wdata_o;
  logic        csr_wen_o;
  logic        csr_ecall_o;
  logic        csr_mret_o;
  logic [31:0] csr_mepc_o;
  logic [31:0] csr_mcause_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [4:0]  rd_o;
  logic [31:0] rd_wdata_o;
  logic        rd_wen_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  csr_exec_unit #(.XLEN(32), .MCAUSE_ECALL(11)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .src1_i(src1_i), .rs1_idx_i(rs1_idx_i), .rd_i(rd_i),
    .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
    .is_ecall_i(is_ecall_i), .is_mret_i(is_mret_i),
    .csr_addr_o(csr_addr_o), .csr_rdata_i(csr_rdata_i),
    .csr_wdata_o(csr_wdata_o), .csr_wen_o(csr_wen_o),
    .csr_ecall_o(csr_ecall_o), .csr_mret_o(csr_mret_o),
    .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rd_o(rd_o), .rd_wdata_o(rd_wdata_o), .rd_wen_o(rd_wen_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one instruction for a single cycle; on return the DUT is in READ
  task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] s1,
                       input logic [4:0] rs1, input logic [4:0] rd, input logic ec,
                       input logic mr, input logic [31:0] pc);
    csr_op_i = op; csr_addr_i = addr; src1_i = s1; rs1_idx_i = rs1; rd_i = rd;
    is_ecall_i = ec; is_mret_i = mr; pc_i = pc; in_valid_i = 1'b1;
    chk("in_ready_before_issue", in_ready_o, 1'b1);
    step();
    in_valid_i = 1'b0; is_ecall_i = 1'b0; is_mret_i = 1'b0;
  endtask

  task automatic retire();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk("out_valid_after_hs", out_valid_o, 1'b0);
    chk("in_ready_after_hs", in_ready_o, 1'b1);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_csr_wen", csr_wen_o, 1'b0);
    chk("rst_redirect", redirect_o, 1'b0);
    rst_i = 1'b1;
    step();

    // csrrw mtvec, rd=5, old=0
    csr_rdata_i = 32'h0;
    issue(3'b001, 12'h305, 32'h8000_0100, 5'd1, 5'd5, 1'b0, 1'b0, 32'h0);
    chk("rw_read_addr", csr_addr_o, 32'h305);
    chk("rw_read_wen", csr_wen_o, 1'b0);
    chk("rw_read_ecall", csr_ecall_o, 1'b0);
    step();
    chk("rw_write_wen", csr_wen_o, 1'b1);
    chk("rw_write_wdata", csr_wdata_o, 32'h8000_0100);
    chk("rw_write_out_valid", out_valid_o, 1'b0);
    step();
    chk("rw_done_out_valid", out_valid_o, 1'b1);
    chk("rw_done_wen_dropped", csr_wen_o, 1'b0);
    chk("rw_rd", rd_o, 32'd5);
    chk("rw_rd_wdata", rd_wdata_o, 32'h0);
    chk("rw_rd_wen", rd_wen_o, 1'b1);
    chk("rw_redirect", redirect_o, 1'b0);
    retire();

    // csrrs mstatus, old=0x1800, src1=0x8
    csr_rdata_i = 32'h1800;
    issue(3'b010, 12'h300, 32'h8, 5'd3, 5'd6, 1'b0, 1'b0, 32'h0);
    step();
    chk("rs_wen", csr_wen_o, 1'b1);
    chk("rs_wdata", csr_wdata_o, 32'h1808);
    step();
    chk("rs_rd_wdata", rd_wdata_o, 32'h1800);
    chk("rs_rd_wen", rd_wen_o, 1'b1);
    retire();

    // csrrc with rs1_idx=0: read only
    csr_rdata_i = 32'hABCD;
    issue(3'b011, 12'h341, 32'hFFFF, 5'd0, 5'd7, 1'b0, 1'b0, 32'h0);
    step();
    chk("rc0_wen", csr_wen_o, 1'b0);
    step();
    chk("rc0_wen_done", csr_wen_o, 1'b0);
    chk("rc0_rd_wdata", rd_wdata_o, 32'hABCD);
    chk("rc0_rd_wen", rd_wen_o, 1'b1);
    retire();

    // csrrci zimm=5 on 0xFF with rd=0: writes 0xFA, no rd writeback
    csr_rdata_i = 32'hFF;
    issue(3'b111, 12'h342, 32'h0, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0);
    step();
    chk("rci_wen", csr_wen_o, 1'b1);
    chk("rci_wdata", csr_wdata_o, 32'hFA);
    step();
    chk("rci_rd_wen_rd0", rd_wen_o, 1'b0);
    retire();

    // ecall at 0x80000040, mtvec=0x80000100
    csr_rdata_i = 32'h8000_0100;
    issue(3'b000, 12'h000, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h8000_0040);
    chk("ecall_read_strobe", csr_ecall_o, 1'b1);
    chk("ecall_read_mepc", csr_mepc_o, 32'h8000_0040);
    chk("ecall_read_mcause", csr_mcause_o, 32'd11);
    step();
    chk("ecall_write_strobe", csr_ecall_o, 1'b1);
    chk("ecall_write_wen", csr_wen_o, 1'b1);
    chk("ecall_write_mepc", csr_mepc_o, 32'h8000_0040);
    chk("ecall_write_mcause", csr_mcause_o, 32'd11);
    step();
    chk("ecall_done_strobe", csr_ecall_o, 1'b0);
    chk("ecall_redirect", redirect_o, 1'b1);
    chk("ecall_redirect_pc", redirect_pc_o, 32'h8000_0100);
    chk("ecall_rd_wen", rd_wen_o, 1'b0);
    retire();

    // mret with mepc=0x80000044, downstream stalls 4 cycles
    csr_rdata_i = 32'h8000_0044;
    issue(3'b000, 12'h000, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0);
    chk("mret_read_strobe", csr_mret_o, 1'b1);
    chk("mret_read_ecall", csr_ecall_o, 1'b0);
    step();
    chk("mret_write_strobe", csr_mret_o, 1'b1);
    chk("mret_write_wen", csr_wen_o, 1'b1);
    step();
    csr_rdata_i = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      chk("mret_stall_valid", out_valid_o, 1'b1);
      chk("mret_stall_redirect", redirect_o, 1'b1);
      chk("mret_stall_pc", redirect_pc_o, 32'h8000_0044);
      chk("mret_stall_in_ready", in_ready_o, 1'b0);
      chk("mret_stall_rd_wen", rd_wen_o, 1'b0);
      step();
    end
    chk("mret_final_valid", out_valid_o, 1'b1);
    retire();

    // funct3 100 is a no-op in the default build
    csr_rdata_i = 32'h77;
    issue(3'b100, 12'h300, 32'hFFFF_FFFF, 5'd4, 5'd8, 1'b0, 1'b0, 32'h0);
    chk("nop_read_ecall", csr_ecall_o, 1'b0);
    step();
    chk("nop_wen", csr_wen_o, 1'b0);
    step();
    chk("nop_valid", out_valid_o, 1'b1);
    chk("nop_rd_wen", rd_wen_o, 1'b0);
    chk("nop_redirect", redirect_o, 1'b0);
    retire();

    // reset asserted during WRITE
    csr_rdata_i = 32'h0;
    issue(3'b001, 12'h305, 32'hDEAD_BEEF, 5'd2, 5'd3, 1'b0, 1'b0, 32'h0);
    step();
    chk("rstw_pre_wen", csr_wen_o, 1'b1);
    #1 rst_i = 1'b0;
    #1;
    chk("rstw_wen", csr_wen_o, 1'b0);
    chk("rstw_in_ready", in_ready_o, 1'b1);
    chk("rstw_out_valid", out_valid_o, 1'b0);
    step();
    rst_i = 1'b1;
    step();
    chk("rstw_post_in_ready", in_ready_o, 1'b1);
    chk("rstw_post_out_valid", out_valid_o, 1'b0);

    // csrrwi zimm=7 after reset
    csr_rdata_i = 32'h55;
    issue(3'b101, 12'h300, 32'hFFFF_FFFF, 5'd7, 5'd9, 1'b0, 1'b0, 32'h0);
    step();
    chk("rwi_wen", csr_wen_o, 1'b1);
    chk("rwi_wdata", csr_wdata_o, 32'h7);
    step();
    chk("rwi_valid", out_valid_o, 1'b1);
    chk("rwi_rd", rd_o, 32'd9);
    chk("rwi_rd_wdata", rd_wdata_o, 32'h55);
    chk("rwi_rd_wen", rd_wen_o, 1'b1);
    retire();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
